// File: rtl/hazard_ctrl.sv
// Scoreboard hazard controller for the 5-stage pipeline: tracks in-flight register writes
// and stalls IF/ID while a decoding instruction's sources are not ready. `HAZ_FWD_EN` enables forwarding-aware readiness.
module hazard_ctrl #(
  parameter int unsigned WB_DIST = 3,
  parameter int unsigned CNT_W   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_addra,
  input  logic [4:0]  id_addrb,
  input  logic        id_usea,
  input  logic        id_useb,
  input  logic        id_isbranch,
  input  logic        id_writereg,
  input  logic [4:0]  id_regdest,
  input  logic        id_readmem,
  input  logic        pipe_freeze,
  output logic        hz_if_hold,
  output logic        hz_ex_bubble,
  output logic [15:0] hz_stallcnt
);

  localparam int unsigned NREG   = 32;
  localparam int unsigned SCNT_W = 16;

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic              ld_q  [NREG];
  logic              ld_d  [NREG];
  logic [SCNT_W-1:0] stallcnt_q;
  logic [SCNT_W-1:0] stallcnt_d;

  logic [CNT_W-1:0]  cnt_a_c;
  logic [CNT_W-1:0]  cnt_b_c;
  logic              busy_a_c;
  logic              busy_b_c;
  logic              stall_c;
  logic              issue_c;

  assign cnt_a_c = cnt_q[id_addra];
  assign cnt_b_c = cnt_q[id_addrb];

`ifdef HAZ_FWD_EN
  logic ld_a_c;
  logic ld_b_c;

  assign ld_a_c = ld_q[id_addra];
  assign ld_b_c = ld_q[id_addrb];

  // Readiness once EX/MEM forwarding exists; branches compare in ID so need values earlier.
  function automatic logic fwd_busy(input logic [CNT_W-1:0] c, input logic ld, input logic br);
    if (br && ld) begin
      return c >= CNT_W'(WB_DIST - 1);
    end else if (br || ld) begin
      return c == CNT_W'(WB_DIST);
    end else begin
      return 1'b0;
    end
  endfunction

  assign busy_a_c = id_usea && (id_addra != 5'd0) && fwd_busy(cnt_a_c, ld_a_c, id_isbranch);
  assign busy_b_c = id_useb && (id_addrb != 5'd0) && fwd_busy(cnt_b_c, ld_b_c, id_isbranch);
`else
  logic unused_isbranch;

  assign unused_isbranch = id_isbranch;
  assign busy_a_c = id_usea && (id_addra != 5'd0) && (cnt_a_c != '0);
  assign busy_b_c = id_useb && (id_addrb != 5'd0) && (cnt_b_c != '0);
`endif

  assign stall_c      = id_valid && (busy_a_c || busy_b_c);
  assign hz_if_hold   = stall_c || pipe_freeze;
  assign hz_ex_bubble = stall_c && !pipe_freeze;
  assign issue_c      = id_valid && !hz_if_hold;
  assign hz_stallcnt  = stallcnt_q;

  // Countdown per entry; a new writer's load wins over the decrement of the same entry.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      ld_d[r]  = ld_q[r];
    end
    if (!pipe_freeze) begin
      for (int r = 1; r < NREG; r++) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
      if (issue_c && id_writereg && (id_regdest != 5'd0)) begin
        cnt_d[id_regdest] = CNT_W'(WB_DIST);
        ld_d[id_regdest]  = id_readmem;
      end
    end
    cnt_d[0] = '0;
    ld_d[0]  = 1'b0;
  end

  always_comb begin
    stallcnt_d = stallcnt_q;
    if (hz_ex_bubble && (stallcnt_q != '1)) begin
      stallcnt_d = stallcnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
        ld_q[r]  <= 1'b0;
      end
      stallcnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
        ld_q[r]  <= ld_d[r];
      end
      stallcnt_q <= stallcnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a ready-time model
// (each register remembers the unfrozen-cycle time at which its pending write becomes visible).
module tb_hazard_ctrl;

  localparam int unsigned WB = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_addra = '0;
  logic [4:0]  id_addrb = '0;
  logic        id_usea = 1'b0;
  logic        id_useb = 1'b0;
  logic        id_isbranch = 1'b0;
  logic        id_writereg = 1'b0;
  logic [4:0]  id_regdest = '0;
  logic        id_readmem = 1'b0;
  logic        pipe_freeze = 1'b0;
  logic        hz_if_hold;
  logic        hz_ex_bubble;
  logic [15:0] hz_stallcnt;

  int vectors = 0;
  int miscompares = 0;

  // Model state: t counts unfrozen edges; rdy[r] is the t at which r becomes readable.
  int unsigned t = 0;
  int unsigned rdy [32];
  bit          ldm [32];
  int unsigned scnt = 0;

  hazard_ctrl #(.WB_DIST(3), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_addra(id_addra), .id_addrb(id_addrb), .id_usea(id_usea), .id_useb(id_useb),
    .id_isbranch(id_isbranch), .id_writereg(id_writereg), .id_regdest(id_regdest),
    .id_readmem(id_readmem), .pipe_freeze(pipe_freeze),
    .hz_if_hold(hz_if_hold), .hz_ex_bubble(hz_ex_bubble), .hz_stallcnt(hz_stallcnt)
  );

  always #5 clock = ~clock;

  function automatic int unsigned remaining(input int addr);
    return (rdy[addr] > t) ? rdy[addr] - t : 0;
  endfunction

  function automatic bit src_stall(input bit use_x, input int addr);
    int unsigned c;
    if (!use_x || addr == 0) return 1'b0;
    c = remaining(addr);
`ifdef HAZ_FWD_EN
    if (id_isbranch && ldm[addr]) return c >= WB - 1;
    if (id_isbranch || ldm[addr]) return c == WB;
    return 1'b0;
`else
    return c != 0;
`endif
  endfunction

  function automatic bit exp_stall();
    return id_valid && (src_stall(id_usea, int'(id_addra)) || src_stall(id_useb, int'(id_addrb)));
  endfunction

  task automatic check(input string nm, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, expv);
    end
  endtask

  // Reference model update.
  initial begin
    for (int i = 0; i < 32; i++) begin
      rdy[i] = 0;
      ldm[i] = 1'b0;
    end
    forever begin
      bit st;
      @(posedge clock or negedge reset);
      if (!reset) begin
        t = 0;
        for (int i = 0; i < 32; i++) begin
          rdy[i] = 0;
          ldm[i] = 1'b0;
        end
        scnt = 0;
      end else begin
        st = exp_stall();
        if (st && !pipe_freeze && scnt < 32'd65535) scnt++;
        if (!pipe_freeze) begin
          t++;
          if (id_valid && !st && id_writereg && id_regdest != 5'd0) begin
            rdy[id_regdest] = t + WB;
            ldm[id_regdest] = id_readmem;
          end
        end
      end
    end
  end

  // Per-cycle compare at the falling edge.
  initial begin
    forever begin
      bit st;
      @(negedge clock);
      st = exp_stall();
      check("if_hold", int'(hz_if_hold), int'(st || pipe_freeze));
      check("ex_bubble", int'(hz_ex_bubble), int'(st && !pipe_freeze));
      check("stallcnt", int'(hz_stallcnt), int'(scnt));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic ins(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                     input logic br, input logic wr, input logic [4:0] d, input logic mem);
    id_valid = 1'b1; id_addra = a; id_addrb = b; id_usea = ua; id_useb = ub;
    id_isbranch = br; id_writereg = wr; id_regdest = d; id_readmem = mem;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Hold the current instruction until it issues; returns the bubbles it took.
  task automatic run(input string nm, output int nb);
    bit issued;
    nb = 0;
    issued = 1'b0;
    for (int k = 0; k < 20 && !issued; k++) begin
      @(negedge clock);
      #1;
      issued = !hz_if_hold;
      if (hz_ex_bubble) nb++;
      cyc();
    end
    if (!issued) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: instruction never issued within 20 cycles", nm);
    end
  endtask

  initial begin
    int nb;
`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    check("rst_stallcnt", int'(hz_stallcnt), 0);
    check("rst_bubble", int'(hz_ex_bubble), 0);
    pipe_freeze = 1'b1;
    #1;
    check("rst_hold_freeze", int'(hz_if_hold), 1);
    pipe_freeze = 1'b0;
    reset = 1'b1;
    cyc();

    // addu r3 then subu r3
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0); run("w_r3", nb);
    ins(5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0); run("raw_alu", nb);
    check("raw_alu_bubbles", nb, FWD ? 0 : 3);
    check("raw_alu_stallcnt", int'(hz_stallcnt), FWD ? 0 : 3);

    // lw r5 then addu reading r5 as B
    idle(4);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1); run("lw_r5", nb);
    ins(5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0); run("load_use", nb);
    check("load_use_bubbles", nb, FWD ? 1 : 3);
    check("load_use_stallcnt", int'(hz_stallcnt), FWD ? 1 : 6);

    // addu r7 / lw r7 then beq r7,r0
    idle(4);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0); run("addu_r7", nb);
    ins(5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); run("br_alu", nb);
    check("br_alu_bubbles", nb, FWD ? 1 : 3);
    idle(4);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1); run("lw_r7", nb);
    ins(5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); run("br_load", nb);
    check("br_load_bubbles", nb, FWD ? 2 : 3);

    // r0 never busy; unused sources never stall
    idle(4);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1); run("w_r0", nb);
    ins(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); run("rd_r0", nb);
    check("r0_bubbles", nb, 0);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1); run("w_r10", nb);
    ins(5'd10, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0); run("nouse", nb);
    check("nouse_bubbles", nb, 0);

    // Freeze in the middle of a stall
    idle(4);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1); run("lw_r11", nb);
    ins(5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clock); #1;
    check("pre_freeze_bubble", int'(hz_ex_bubble), 1);
    cyc();
    pipe_freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); #1;
      check("freeze_hold", int'(hz_if_hold), 1);
      check("freeze_bubble", int'(hz_ex_bubble), 0);
      cyc();
    end
    pipe_freeze = 1'b0;
    run("post_freeze", nb);
    check("post_freeze_bubbles", nb, FWD ? 1 : 2);

    // Reset while a consumer is stalled on cnt[3]=2
    idle(4);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1); run("lw_r3", nb);
    ins(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    cyc();
    check("stall_before_reset", int'(hz_ex_bubble), 1);
    #1 reset = 1'b0;
    #1;
    check("reset_bubble_drop", int'(hz_ex_bubble), 0);
    check("reset_hold_drop", int'(hz_if_hold), 0);
    check("reset_stallcnt", int'(hz_stallcnt), 0);
    cyc();
    reset = 1'b1;
    run("after_reset", nb);
    check("after_reset_bubbles", nb, 0);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_addra    = 5'($urandom_range(0, 5));
      id_addrb    = 5'($urandom_range(0, 5));
      id_usea     = 1'($urandom_range(0, 1));
      id_useb     = 1'($urandom_range(0, 1));
      id_isbranch = ($urandom_range(0, 3) == 0);
      id_writereg = 1'($urandom_range(0, 1));
      id_regdest  = 5'($urandom_range(0, 5));
      id_readmem  = 1'($urandom_range(0, 1));
      pipe_freeze = ($urandom_range(0, 9) == 0);
      cyc();
    end
    pipe_freeze = 1'b0;

`ifndef HAZ_FWD_EN
    // Back-to-back self-dependent instructions drive the counter into saturation
    ins(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    repeat (87500) cyc();
    check("stallcnt_saturated", int'(hz_stallcnt), 65535);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
